// File: rtl/mux_5x1_arbiter_if.sv
// Request/grant bundle between five requesters and the mux_5x1 selector arbiter.
// Latency: n/a (wires only).
// Backpressure: none; requesters hold req until granted and release via done or req drop.
//
// Signals:
//   req[4:0]  requester i asks for selector input i (a=0 .. e=4)
//   done      current owner releases the selector
//   grant[4:0] one-hot grant, all-zero when idle
//   sel[2:0]  selector code, 3'b111 when idle
//   busy      a grant is active
//   timeout   one-cycle pulse after a forced release
interface mux_5x1_arbiter_if;
    logic [4:0] req;
    logic       done;
    logic [4:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;

    // Arbiter side.
    modport master (
        input  req,
        input  done,
        output grant,
        output sel,
        output busy,
        output timeout
    );

    // Requester / selector side.
    modport slave (
        output req,
        output done,
        input  grant,
        input  sel,
        input  busy,
        input  timeout
    );
endinterface

// File: rtl/mux_5x1_arbiter.sv
// Round-robin arbiter driving the sel input of a 5:1 selector, one owner at a time.
// Latency: req to grant/sel one edge; done or req[cur] drop to release one edge.
// Backpressure: no preemption; an owner keeps the selector until done, req drop or MAX_HOLD cycles.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    mux_5x1_arbiter_if.master (req, done in; grant, sel, busy, timeout out, all registered)
module mux_5x1_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    mux_5x1_arbiter_if.master      bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
    localparam logic [2:0] SEL_IDLE  = 3'b111;

    state_t     state_q, state_n;
    logic [2:0] cur_q, cur_n;
    logic [2:0] last_q, last_n;
    logic [3:0] hold_q, hold_n;
    logic [4:0] grant_q, grant_n;
    logic [2:0] sel_q, sel_n;
    logic       busy_q, busy_n;
    logic       timeout_q, timeout_n;

    // Round-robin search: scan last+1, last+2, ... modulo 5, first set request wins.
    logic [2:0] cand;
    logic [2:0] win;
    logic       found;

    always_comb begin
        cand  = last_q;
        win   = 3'd0;
        found = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cand = (cand == 3'd4) ? 3'd0 : cand + 3'd1;
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    logic owner_req;
    logic at_limit;
    logic release_now;

    assign owner_req   = bus.req[cur_q];
    assign at_limit    = (hold_q == HOLD_LAST);
    assign release_now = bus.done | ~owner_req | at_limit;

    always_comb begin
        state_n   = state_q;
        cur_n     = cur_q;
        last_n    = last_q;
        hold_n    = hold_q;
        grant_n   = grant_q;
        sel_n     = sel_q;
        busy_n    = busy_q;
        timeout_n = 1'b0;

        case (state_q)
            IDLE: begin
                grant_n = 5'b00000;
                sel_n   = SEL_IDLE;
                busy_n  = 1'b0;
                hold_n  = 4'd0;
                if (found) begin
                    state_n = BUSY;
                    cur_n   = win;
                    last_n  = win;
                    grant_n = 5'b00001 << win;
                    sel_n   = win;
                    busy_n  = 1'b1;
                end
            end
            BUSY: begin
                if (release_now) begin
                    state_n   = IDLE;
                    grant_n   = 5'b00000;
                    sel_n     = SEL_IDLE;
                    busy_n    = 1'b0;
                    hold_n    = 4'd0;
                    // Only a pure hold-limit release counts as a timeout.
                    timeout_n = at_limit & ~bus.done & owner_req;
                end else begin
                    hold_n = hold_q + 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = 5'b00000;
                sel_n   = SEL_IDLE;
                busy_n  = 1'b0;
                hold_n  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cur_q     <= 3'd0;
            last_q    <= 3'd4;   // first search starts at index 0
            hold_q    <= 4'd0;
            grant_q   <= 5'b00000;
            sel_q     <= SEL_IDLE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            cur_q     <= cur_n;
            last_q    <= last_n;
            hold_q    <= hold_n;
            grant_q   <= grant_n;
            sel_q     <= sel_n;
            busy_q    <= busy_n;
            timeout_q <= timeout_n;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mux_5x1_arbiter.sv
module tb_mux_5x1_arbiter;

    logic clk;
    logic reset;

    mux_5x1_arbiter_if ifc ();

    mux_5x1_arbiter #(.MAX_HOLD(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected output word: {grant[4:0], sel[2:0], busy, timeout}.
    logic [9:0] exp_q[$];
    logic [9:0] e;
    int total = 0;
    int bad   = 0;

    function automatic logic [9:0] e_idle(input logic to);
        return {5'b00000, 3'b111, 1'b0, to};
    endfunction

    function automatic logic [9:0] e_gnt(input int i);
        logic [4:0] g;
        logic [2:0] s;
        g = 5'b00001 << i;
        s = 3'(i);
        return {g, s, 1'b1, 1'b0};
    endfunction

    function automatic logic [9:0] obs();
        return {ifc.grant, ifc.sel, ifc.busy, ifc.timeout};
    endfunction

    // Drive one cycle of stimulus, push its expected result, and move 1 time unit past the edge.
    task automatic step(input logic r, input logic [4:0] rq, input logic d, input logic [9:0] ex);
        exp_q.push_back(ex);
        reset   = r;
        ifc.req = rq;
        ifc.done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            step(1'b1, 5'b11111, 1'b0, e_idle(1'b0));
            e = exp_q.pop_front();
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL reset cyc%0d got=%b want=%b", c, obs(), e);
            end
        end
        step(1'b0, 5'b00000, 1'b0, e_idle(1'b0));
        e = exp_q.pop_front();
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL reset_release got=%b want=%b", obs(), e);
        end
    endtask

    task automatic test_single();
        logic [4:0] rq [6];
        logic       dn [6];
        logic [9:0] ex [6];
        step(1'b1, 5'b00000, 1'b0, e_idle(1'b0));
        void'(exp_q.pop_front());
        rq = '{5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00000};
        dn = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        ex = '{e_gnt(2), e_gnt(2), e_gnt(2), e_idle(1'b0), e_gnt(2), e_idle(1'b0)};
        for (int c = 0; c < 6; c++) begin
            step(1'b0, rq[c], dn[c], ex[c]);
            e = exp_q.pop_front();
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL single cyc%0d got=%b want=%b", c, obs(), e);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] seq [11];
        logic [9:0] ex;
        step(1'b1, 5'b00000, 1'b0, e_idle(1'b0));
        void'(exp_q.pop_front());
        seq = '{3'd0, 3'd7, 3'd1, 3'd7, 3'd2, 3'd7, 3'd3, 3'd7, 3'd4, 3'd7, 3'd0};
        for (int c = 0; c < 11; c++) begin
            ex = (seq[c] == 3'd7) ? e_idle(1'b0) : e_gnt(int'(seq[c]));
            step(1'b0, 5'b11111, 1'b1, ex);
            e = exp_q.pop_front();
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL round_robin cyc%0d got=%b want=%b", c, obs(), e);
            end
        end
    endtask

    task automatic test_timeout();
        logic [9:0] ex;
        step(1'b1, 5'b00000, 1'b0, e_idle(1'b0));
        void'(exp_q.pop_front());
        // 8 grant cycles, a timeout idle cycle, a regrant, then idle once req goes away.
        for (int c = 0; c < 11; c++) begin
            if (c < 8)       ex = e_gnt(3);
            else if (c == 8) ex = e_idle(1'b1);
            else if (c == 9) ex = e_gnt(3);
            else             ex = e_idle(1'b0);
            step(1'b0, (c < 10) ? 5'b01000 : 5'b00000, 1'b0, ex);
            e = exp_q.pop_front();
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL timeout cyc%0d got=%b want=%b", c, obs(), e);
            end
        end
    endtask

    task automatic test_req_drop();
        logic [4:0] rq [5];
        logic [9:0] ex [5];
        step(1'b1, 5'b00000, 1'b0, e_idle(1'b0));
        void'(exp_q.pop_front());
        rq = '{5'b10010, 5'b10010, 5'b10010, 5'b10000, 5'b10000};
        ex = '{e_gnt(1), e_gnt(1), e_gnt(1), e_idle(1'b0), e_gnt(4)};
        for (int c = 0; c < 5; c++) begin
            step(1'b0, rq[c], 1'b0, ex[c]);
            e = exp_q.pop_front();
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL req_drop cyc%0d got=%b want=%b", c, obs(), e);
            end
        end
    endtask

    task automatic test_done_at_limit();
        step(1'b1, 5'b00000, 1'b0, e_idle(1'b0));
        void'(exp_q.pop_front());
        for (int c = 0; c < 10; c++) begin
            step(1'b0, (c < 9) ? 5'b00001 : 5'b00000, (c == 8) ? 1'b1 : 1'b0,
                 (c < 8) ? e_gnt(0) : e_idle(1'b0));
            e = exp_q.pop_front();
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL done_at_limit cyc%0d got=%b want=%b", c, obs(), e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] ex [4];
        logic [4:0] rq [4];
        logic       rs [4];
        step(1'b1, 5'b00000, 1'b0, e_idle(1'b0));
        void'(exp_q.pop_front());
        rs = '{1'b0, 1'b0, 1'b1, 1'b0};
        rq = '{5'b01000, 5'b11111, 5'b11111, 5'b11111};
        ex = '{e_gnt(3), e_gnt(3), e_idle(1'b0), e_gnt(0)};
        for (int c = 0; c < 4; c++) begin
            step(rs[c], rq[c], 1'b0, ex[c]);
            e = exp_q.pop_front();
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL reset_mid cyc%0d got=%b want=%b", c, obs(), e);
            end
        end
    endtask

    // Two requesters held with no done: alternating forced releases show the pointer advancing.
    task automatic test_back_to_back();
        logic [9:0] ex;
        step(1'b1, 5'b00000, 1'b0, e_idle(1'b0));
        void'(exp_q.pop_front());
        for (int c = 0; c < 20; c++) begin
            if (c < 8)        ex = e_gnt(0);
            else if (c == 8)  ex = e_idle(1'b1);
            else if (c < 17)  ex = e_gnt(1);
            else if (c == 17) ex = e_idle(1'b1);
            else              ex = e_gnt(0);
            step(1'b0, 5'b00011, 1'b0, ex);
            e = exp_q.pop_front();
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL back_to_back cyc%0d got=%b want=%b", c, obs(), e);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        ifc.req  = 5'b00000;
        ifc.done = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_req_drop();
        test_done_at_limit();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_5x1_arbiter.md
# mux_5x1_arbiter

Round-robin arbiter and sequencer for the 5:1 single-bit selector (`mux_5x1`). It shares the selector between five requesters by driving its 3-bit `sel`. One requester is granted at a time, with a bounded hold time. While no grant is active, `sel` is parked on an invalid code so the selector output is 0. The block sits directly in front of the selector's `sel` input, and `grant` returns to the requesters.

## Interface
Parameters:
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per winner. Legal range is 1..15, held in a 4-bit counter.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `req`, input, 5: request lines. Bit i corresponds to selector input i (a=0 … e=4).
- `done`, input, 1: the current owner releases the selector. Sampled only while busy.
- `grant`, output, 5: one-hot grant, or all-zero when idle. Registered.
- `sel`, output, 3: selector code, equal to the granted index (000..100). It is 3'b111 when idle. Registered.
- `busy`, output, 1: high while any grant is active. Registered.
- `timeout`, output, 1: one-cycle pulse when a grant is force-released by `MAX_HOLD`. Registered.

## Operation
- The state machine has two states, IDLE and BUSY. Internal state is:
  - `cur`: 3-bit index of the current owner.
  - `last`: 3-bit index of the last winner, the round-robin pointer.
  - `hold_cnt`: 4-bit count of cycles spent in BUSY.
- Reset values:
  - State IDLE, `grant`=5'b00000, `sel`=3'b111, `busy`=0, `timeout`=0.
  - `last`=4, so the first search starts at index 0. `hold_cnt`=0.
- IDLE behaviour:
  - If `req` is zero, stay in IDLE. Outputs stay at their idle values (`grant`=0, `sel`=111, `busy`=0). `timeout` falls to 0 after its pulse cycle.
  - Otherwise the winner is the first set bit scanning last+1, last+2, … modulo 5. The index after 4 is 0; index values 5..7 never occur.
  - On the next edge the block enters BUSY with `cur`=`last`=winner, `grant`=1<<winner, `sel`=winner, `busy`=1, `hold_cnt`=0, `timeout`=0.
- BUSY behaviour. At each edge, evaluate the release conditions:
  - (a) `done`=1;
  - (b) `req[cur]`=0;
  - (c) `hold_cnt`==`MAX_HOLD`-1.
- If any release condition holds, return to IDLE: `grant`=0, `sel`=111, `busy`=0, `hold_cnt`=0.
  - `timeout`=1 only when (c) holds and both (a) and (b) are false.
- If no release condition holds, stay in BUSY with `hold_cnt`+1. Outputs are unchanged.
- Changes on `req` bits other than `cur` are ignored while BUSY; there is no preemption.
- After every release, IDLE lasts at least one cycle. The selector output is 0 for that cycle, which guarantees a clean handover.
- `sel` and `grant` always change on the same edge and always agree. `sel`=111 if and only if `grant`=0.

## Timing
- Request to grant latency: `req` sampled high at edge N (while in IDLE) gives `grant` and `sel` valid after edge N, i.e. in cycle N+1.
- Release latency: `done` or a `req[cur]` drop sampled at edge M gives `grant` = 0 after edge M.
- Maximum grant length is `MAX_HOLD` cycles. Handover period is at least 1 idle cycle.
- Worst-case wait for a continuously requesting input is 4×(`MAX_HOLD`+1) cycles.
- `timeout` is high for exactly the one idle cycle after a forced release.
- `reset` has priority over everything, including mid-BUSY. On the next edge all outputs and state return to their reset values regardless of `req` or `done`.
- With `MAX_HOLD`=1, every grant lasts one cycle. `timeout` pulses unless `done` or a `req[cur]` drop coincides on the same edge.

## Test plan
- Reset check: assert `reset` for 2 cycles with `req`=5'b11111 → `grant`=00000, `sel`=111, `busy`=0, `timeout`=0 throughout.
- Single requester:
  - Stimulus: `req`=00100 from cycle 1; `done` pulses in cycle 4.
  - Response: `grant`=00100, `sel`=010, `busy`=1 in cycles 2–4. Idle values from cycle 5. A regrant appears in cycle 6 if `req` is still high.
- Round robin: `req`=11111 held, `done`=1 every busy cycle → `sel` sequence 000,111,001,111,010,111,011,111,100,111,000.
- Timeout:
  - Stimulus: `MAX_HOLD`=8, `req`=01000 held, `done`=0.
  - Response: `grant`=01000 and `sel`=011 for exactly 8 cycles. Then one idle cycle with `timeout`=1. Then a regrant to index 3.
- Request drop and simultaneous events:
  - `req[1]` drops in its 3rd grant cycle while `req[4]` is pending → release, one idle cycle, then `sel`=100.
  - `done`=1 on the hold-limit cycle → release with `timeout`=0.
- Reset mid-operation: `reset` during a grant to index 3 with `req`=11111 → idle values on the next edge. After reset deasserts, the first grant goes to index 0.
